// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline boundary (decode -> execute).
// Signals: in_valid/in_ready/in_data/in_ctrl on the upstream side,
//          out_valid/out_ready/out_data/out_ctrl on the downstream side.
// Modports: slave = the pipeline stage itself, master = the surrounding logic driving it.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic decode-to-execute register: 2-entry skid (main + skid), sync flush kills ctrl.
// Latency 1 cycle from accept to out_valid; 1 entry/cycle sustained when out_ready=1.
// Backpressure: in_ready = ~skid_valid straight from a flop, never combinational on out_ready.
// Ports: clk, reset (async, active-low), flush, bus (pipe_stage_elastic_if.slave),
//        stall_cnt / bubble_cnt (live only when PIPE_STAGE_STATS_EN is defined, else 0).
module pipe_stage_elastic #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int STAT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  bus,
    output logic [STAT_W-1:0]    stall_cnt,
    output logic [STAT_W-1:0]    bubble_cnt
);

    // State encoding is {sv, mv}, so the valid bits are the state flops themselves.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] sdata;
    logic [CTRL_W-1:0] mctrl;
    logic [CTRL_W-1:0] sctrl;
    logic              mv;
    logic              sv;
    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              clear_main;

    assign mv     = state[0];
    assign sv     = state[1];
    assign accept = bus.in_valid & ~sv & ~flush;
    assign drain  = mv & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over every transition
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (accept && !drain)      state_nxt = ST_SKID;
                    else if (!accept && drain) state_nxt = ST_EMPTY;
                end
                ST_SKID:  if (drain) state_nxt = ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Output logic: handshake outputs and datapath load strobes
    always_comb begin
        bus.in_ready   = ~sv;
        bus.out_valid  = mv;
        bus.out_data   = mdata;
        bus.out_ctrl   = mctrl;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        case (state)
            ST_EMPTY: load_main_in = accept;
            ST_FULL: begin
                load_main_in = accept & drain;
                load_skid    = accept & ~drain;
                clear_main   = ~accept & drain;
            end
            ST_SKID:  load_main_skid = drain;
            default: ;
        endcase
    end

    // Payload registers. Ctrl is zeroed whenever its entry goes invalid so that
    // out_ctrl is always safe to use unqualified; data is left as don't-care.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdata <= '0;
            mctrl <= '0;
            sdata <= '0;
            sctrl <= '0;
        end else if (flush) begin
            mctrl <= '0;
            sctrl <= '0;
        end else begin
            if (load_main_in) begin
                mdata <= bus.in_data;
                mctrl <= bus.in_ctrl;
            end else if (load_main_skid) begin
                mdata <= sdata;
                mctrl <= sctrl;
            end else if (clear_main) begin
                mctrl <= '0;
            end

            if (load_skid) begin
                sdata <= bus.in_data;
                sctrl <= bus.in_ctrl;
            end else if (load_main_skid) begin
                sctrl <= '0;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Saturating counters; flush deliberately does not touch them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (mv && !bus.out_ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + STAT_ONE;
            end
            if (!mv && !(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + STAT_ONE;
            end
        end
    end
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic decode-to-execute pipeline register.
- Successor to the fixed-width flop-with-clear stage:
  - payload split into a generic data field and a control field;
  - valid/ready handshake;
  - 2-entry skid buffer, so in_ready never depends combinationally on out_ready;
  - synchronous flush that kills control bits like the existing clr.
- Sits between decode and execute. One instance per pipeline boundary.

Parameters:
- DATA_W, 96, data payload width (RD1/RD2/EXTIMM style operands, concatenated).
- CTRL_W, 24, control payload width (write enables, ALU control, cond, flags, register addresses). All-zero means "no side effect".
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries (branch mispredict / clr).
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  incoming data payload.
- in_ctrl  in  CTRL_W  incoming control payload.
- out_valid  out  1  out_data/out_ctrl valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  registered data payload.
- out_ctrl  out  CTRL_W  registered control payload.
- stall_cnt  out  STAT_W  cycles with out_valid=1 and out_ready=0 (optional feature).
- bubble_cnt  out  STAT_W  cycles with out_valid=0 (optional feature).

Behaviour:
- Storage:
  - main register: mv, mdata, mctrl; drives out_*.
  - skid register: sv, sdata, sctrl.
- Events:
  - accept = in_valid & in_ready & ~flush.
  - drain = mv & out_ready.
  - in_ready = ~sv, taken directly from the flop.
- Reset (reset=0, asynchronous):
  - mv=0, sv=0, mctrl=0, sctrl=0, mdata=0, sdata=0.
  - in_ready=1, out_valid=0, counters=0.
- States: EMPTY (mv=0, sv=0), FULL (mv=1, sv=0), SKID (mv=1, sv=1). The state mv=0, sv=1 is unreachable.
- EMPTY transitions:
  - accept: main <- in, go to FULL.
  - otherwise: stay EMPTY.
- FULL transitions:
  - accept & drain: main <- in, stay FULL.
  - accept & ~drain: skid <- in, go to SKID.
  - ~accept & drain: go to EMPTY.
  - neither: hold.
- SKID transitions (in_ready=0, so no accept is possible):
  - drain: main <- skid, sv=0, go to FULL.
  - else: hold.
- Flush (highest priority after reset):
  - next cycle: mv=0, sv=0, mctrl=0, sctrl=0; state EMPTY.
  - mdata/sdata hold their values (don't-care).
  - Same-cycle in_valid is dropped, not stored.
  - Same-cycle out_ready handshake still counts as consumed by downstream.
- Latency and throughput:
  - latency 1 cycle, accept to out_valid, from EMPTY;
  - sustained throughput 1 entry/cycle when out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ctrl do not change.
- Ordering: strictly FIFO; no entry duplicated or lost except on flush.
- Control rule: out_ctrl=0 whenever out_valid=0, so downstream may consume ctrl without qualifying by valid.
- Reset asserted mid-stream: both entries discarded immediately and asynchronously.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid & ~out_ready.
  - bubble_cnt increments every cycle with ~out_valid.
  - Both are STAT_W-bit, saturate at all-ones, unaffected by flush, cleared only by reset.
- Undefined:
  - counter logic not compiled; stall_cnt and bubble_cnt tied to 0.
  - Port list identical in both builds.

Test Plan:
- Reset, then idle 3 cycles:
  - in_ready=1, out_valid=0, out_ctrl=0 throughout.
  - bubble_cnt=3 with macro, 0 without.
- Stream 5 entries (data 0x1..0x5, ctrl 0xA1..0xA5) with out_ready=1:
  - out_valid from cycle+1;
  - data emerges 0x1..0x5 on consecutive cycles;
  - in_ready stays 1.
- Load 0x10 and 0x20 with out_ready=0:
  - after the 2nd accept, in_ready=0 and out_data=0x10 is held;
  - raise out_ready: outputs 0x10, then 0x20;
  - in_ready returns to 1 one cycle after the first drain;
  - stall_cnt equals the number of held cycles.
- State SKID (0x30 in main, 0x40 in skid), assert flush together with in_valid=1 (0x50):
  - next cycle out_valid=0, out_ctrl=0, in_ready=1;
  - 0x30, 0x40 and 0x50 never appear.
- Assert reset=0 asynchronously mid-cycle while FULL:
  - out_valid and in_ready update before the next clk edge (out_valid=0, in_ready=1).
- With macro, hold out_valid=1 and out_ready=0 for 70000 cycles (STAT_W=16): stall_cnt saturates at 0xFFFF.
